nic_traffic_engine: RTL and testbench

- Synthesizable, parametrised NIC-side traffic master/checker for the cardinal_noc mesh. It replaces the hand-driven unicast bench sequence with hardware.
- One instance attaches to one node's NIC register port (addr/di/do/en/we). It injects a programmable burst of packets to a chosen destination and drains and checks packets arriving at its own node.
- Mesh dimensions, burst length and timeout are parameters, so the same block serves 3x3 and larger meshes in multi-node stress and loopback tests.

---
 rtl/nic_traffic_engine.sv | 253 +++++++++++++++++++++++++
 tb/tb_nic_traffic_engine.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nic_traffic_engine.sv
// NIC-side traffic master/checker: injects a programmed burst of packets toward one
// mesh tile and drains/checks the packets that arrive at its own tile.
module nic_traffic_engine #(
  parameter int DW           = 64,
  parameter int MESH_X       = 3,
  parameter int MESH_Y       = 3,
  parameter int SRC_X        = 0,
  parameter int SRC_Y        = 0,
  parameter int CNT_W        = 8,
  parameter int POLL_TIMEOUT = 400
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       dst_x,
  input  logic [2:0]       dst_y,
  input  logic [CNT_W-1:0] tx_num,
  input  logic [CNT_W-1:0] rx_num,
  input  logic [15:0]      exp_src,
  input  logic [15:0]      seed,
  output logic [1:0]       nic_addr,
  output logic [DW-1:0]    nic_di,
  output logic             nic_en,
  output logic             nic_we,
  input  logic [DW-1:0]    nic_do,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             cfg_err,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] err_count,
  output logic [DW-1:0]    last_rx,
  output logic [3:0]       dbg_state
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CHK_OUT = 4'd1,
    WT_OUT  = 4'd2,
    WRITE   = 4'd3,
    CHK_IN  = 4'd4,
    WT_IN   = 4'd5,
    READ    = 4'd6,
    WT_RD   = 4'd7,
    DONE    = 4'd8
  } state_e;

  localparam int              WD_W    = $clog2(POLL_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(POLL_TIMEOUT - 1);
  localparam logic [3:0]      SX      = 4'(SRC_X);
  localparam logic [3:0]      SY      = 4'(SRC_Y);
  localparam logic [15:0]     SRC_ID  = {8'(SRC_Y), 8'(SRC_X)};

  state_e           state_q, state_d;
  logic [2:0]       dst_x_q, dst_x_d, dst_y_q, dst_y_d;
  logic [CNT_W-1:0] tx_num_q, tx_num_d, rx_num_q, rx_num_d;
  logic [15:0]      exp_src_q, exp_src_d, seed_q, seed_d;
  logic [CNT_W-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [DW-1:0]    last_rx_q, last_rx_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             timeout_q, timeout_d, cfg_err_q, cfg_err_d;
  logic [WD_W-1:0]  wd_q, wd_d;

  logic             tx_left, rx_left;
  logic [3:0]       dx, dy, hop_x, hop_y;
  logic [63:0]      pkt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign tx_left = (tx_count_q != tx_num_q);
  assign rx_left = (rx_count_q != rx_num_q);

  // Header: VC=0, direction bits, one-hot-run hop masks, own id, sequence data.
  always_comb begin
    dx    = ({1'b0, dst_x_q} >= SX) ? ({1'b0, dst_x_q} - SX) : (SX - {1'b0, dst_x_q});
    dy    = ({1'b0, dst_y_q} >= SY) ? ({1'b0, dst_y_q} - SY) : (SY - {1'b0, dst_y_q});
    hop_x = 4'((5'd1 << dx) - 5'd1);
    hop_y = 4'((5'd1 << dy) - 5'd1);
    pkt          = '0;
    pkt[62]      = ({1'b0, dst_x_q} < SX);
    pkt[61]      = ({1'b0, dst_y_q} > SY);
    pkt[55:52]   = hop_x;
    pkt[51:48]   = hop_y;
    pkt[47:32]   = SRC_ID;
    pkt[31:16]   = seed_q + 16'(tx_count_q);
  end

  // NIC port: a read (en=1, we=0) returns nic_do one cycle later; a write
  // (en=1, we=1, addr=10) is a single cycle. All NIC outputs are zero otherwise.
  always_comb begin
    state_d     = state_q;
    dst_x_d     = dst_x_q;
    dst_y_d     = dst_y_q;
    tx_num_d    = tx_num_q;
    rx_num_d    = rx_num_q;
    exp_src_d   = exp_src_q;
    seed_d      = seed_q;
    tx_count_d  = tx_count_q;
    rx_count_d  = rx_count_q;
    err_count_d = err_count_q;
    last_rx_d   = last_rx_q;
    busy_d      = busy_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    cfg_err_d   = cfg_err_q;
    wd_d        = wd_q;
    nic_en      = 1'b0;
    nic_we      = 1'b0;
    nic_addr    = 2'b00;
    nic_di      = '0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          dst_x_d     = dst_x;
          dst_y_d     = dst_y;
          tx_num_d    = tx_num;
          rx_num_d    = rx_num;
          exp_src_d   = exp_src;
          seed_d      = seed;
          tx_count_d  = '0;
          rx_count_d  = '0;
          err_count_d = '0;
          last_rx_d   = '0;
          done_d      = 1'b0;
          timeout_d   = 1'b0;
          cfg_err_d   = 1'b0;
          wd_d        = '0;
          if (int'(dst_x) >= MESH_X || int'(dst_y) >= MESH_Y) begin
            cfg_err_d = 1'b1;
            done_d    = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = CHK_OUT;
          end
        end
      end
      CHK_OUT: begin
        if (!tx_left) begin
          state_d = rx_left ? CHK_IN : DONE;
        end else begin
          nic_en   = 1'b1;
          nic_addr = 2'b11;
          state_d  = WT_OUT;
        end
      end
      // A full output queue yields to the drain side so reception never starves.
      WT_OUT: state_d = nic_do[0] ? CHK_IN : WRITE;
      WRITE: begin
        nic_en     = 1'b1;
        nic_we     = 1'b1;
        nic_addr   = 2'b10;
        nic_di     = DW'(pkt);
        tx_count_d = sat_inc(tx_count_q);
        state_d    = CHK_IN;
      end
      CHK_IN: begin
        if (!rx_left) begin
          state_d = tx_left ? CHK_OUT : DONE;
        end else begin
          nic_en   = 1'b1;
          nic_addr = 2'b01;
          state_d  = WT_IN;
        end
      end
      WT_IN: state_d = nic_do[0] ? READ : CHK_OUT;
      READ: begin
        nic_en   = 1'b1;
        nic_addr = 2'b00;
        state_d  = WT_RD;
      end
      WT_RD: begin
        last_rx_d  = nic_do;
        rx_count_d = sat_inc(rx_count_q);
        if (nic_do[47:32] != exp_src_q || nic_do[31:16] != seed_q + 16'(rx_count_q))
          err_count_d = sat_inc(err_count_q);
        state_d = CHK_OUT;
      end
      default: state_d = IDLE;
    endcase

    // Watchdog: any completed transfer counts as progress.
    if (state_q == WRITE || state_q == WT_RD) begin
      wd_d = '0;
    end else if (busy_q) begin
      if (wd_q == WD_LAST) begin
        timeout_d = 1'b1;
        state_d   = DONE;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end

    if (state_d == DONE && state_q != DONE) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      dst_x_q     <= '0;
      dst_y_q     <= '0;
      tx_num_q    <= '0;
      rx_num_q    <= '0;
      exp_src_q   <= '0;
      seed_q      <= '0;
      tx_count_q  <= '0;
      rx_count_q  <= '0;
      err_count_q <= '0;
      last_rx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      dst_x_q     <= dst_x_d;
      dst_y_q     <= dst_y_d;
      tx_num_q    <= tx_num_d;
      rx_num_q    <= rx_num_d;
      exp_src_q   <= exp_src_d;
      seed_q      <= seed_d;
      tx_count_q  <= tx_count_d;
      rx_count_q  <= rx_count_d;
      err_count_q <= err_count_d;
      last_rx_q   <= last_rx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      cfg_err_q   <= cfg_err_d;
      wd_q        <= wd_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign cfg_err   = cfg_err_q;
  assign tx_count  = tx_count_q;
  assign rx_count  = rx_count_q;
  assign err_count = err_count_q;
  assign last_rx   = last_rx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_nic_traffic_engine.sv
// Bench for nic_traffic_engine: a behavioural NIC stub plus a packet model derived
// from the header rules, driven with fixed and randomized runs.
module tb_nic_traffic_engine;

  localparam int DW = 64, MX = 5, MY = 3, SX = 4, SY = 1, CW = 8, PT = 50;
  localparam logic [15:0] OWN_ID = 16'h0104;

  logic clk = 1'b0;
  logic reset, start;
  logic [2:0] dst_x, dst_y;
  logic [CW-1:0] tx_num, rx_num, tx_count, rx_count, err_count;
  logic [15:0] exp_src, seed;
  logic [1:0] nic_addr;
  logic [DW-1:0] nic_di, last_rx;
  logic [DW-1:0] nic_do = '0;
  logic nic_en, nic_we, busy, done, timeout, cfg_err;
  logic [3:0] dbg_state;

  int n_checks = 0, n_fail = 0;

  // NIC stub state
  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] tx_log[$];
  logic [DW-1:0] rx_seen[$];
  logic [DW-1:0] exp_q[$];
  int read_cyc_q[$];
  bit out_full_stall = 0, rand_full = 0, loopback = 0;
  int cyc = 0, en_cycles = 0, proto_err = 0, write_cyc = 0;

  nic_traffic_engine #(
    .DW(DW), .MESH_X(MX), .MESH_Y(MY), .SRC_X(SX), .SRC_Y(SY), .CNT_W(CW), .POLL_TIMEOUT(PT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .dst_x(dst_x), .dst_y(dst_y),
    .tx_num(tx_num), .rx_num(rx_num), .exp_src(exp_src), .seed(seed),
    .nic_addr(nic_addr), .nic_di(nic_di), .nic_en(nic_en), .nic_we(nic_we), .nic_do(nic_do),
    .busy(busy), .done(done), .timeout(timeout), .cfg_err(cfg_err),
    .tx_count(tx_count), .rx_count(rx_count), .err_count(err_count), .last_rx(last_rx),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (nic_en) en_cycles++;
    if (!nic_en && (nic_we || nic_addr != 2'b00 || nic_di != '0)) proto_err++;
    if (nic_we && !(nic_en && nic_addr == 2'b10)) proto_err++;
    if (nic_en && nic_we) begin
      tx_log.push_back(nic_di);
      write_cyc = cyc;
      if (loopback) rx_q.push_back(nic_di);
    end else if (nic_en) begin
      case (nic_addr)
        2'b00: begin
          if (rx_q.size() != 0) begin
            rx_seen.push_back(rx_q[0]);
            nic_do <= rx_q.pop_front();
          end else begin
            nic_do <= '0;
          end
          read_cyc_q.push_back(cyc);
        end
        2'b01: nic_do <= {63'b0, rx_q.size() != 0};
        2'b11: nic_do <= {63'b0, out_full_stall | (rand_full && $urandom_range(0, 3) == 0)};
        default: nic_do <= '0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not reach its summary");
    $fatal(1);
  end

  // Reference packet built straight from the header field definitions.
  function automatic logic [63:0] model_pkt(input int tx, input int ty, input logic [15:0] data);
    int adx, ady;
    logic [63:0] p;
    adx = (tx > SX) ? tx - SX : SX - tx;
    ady = (ty > SY) ? ty - SY : SY - ty;
    p = '0;
    p[62] = (tx < SX);
    p[61] = (ty > SY);
    p[55:52] = 4'((1 << adx) - 1);
    p[51:48] = 4'((1 << ady) - 1);
    p[47:32] = OWN_ID;
    p[31:16] = data;
    return p;
  endfunction

  task automatic clear_stub();
    rx_q.delete(); tx_log.delete(); rx_seen.delete(); exp_q.delete(); read_cyc_q.delete();
    out_full_stall = 0; rand_full = 0; loopback = 0; proto_err = 0;
  endtask

  task automatic do_start(input int tx, input int ty, input int txn, input int rxn,
                          input logic [15:0] es, input logic [15:0] sd);
    @(posedge clk); #1;
    dst_x = 3'(tx); dst_y = 3'(ty); tx_num = CW'(txn); rx_num = CW'(rxn);
    exp_src = es; seed = sd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < max_cyc) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({nic_en, nic_we, nic_addr, nic_di, busy, done, timeout, cfg_err} !== '0) begin
      n_fail++; $display("FAIL reset_ctrl: got en=%b we=%b addr=%b di=%h busy=%b done=%b to=%b cfg=%b required all 0",
        nic_en, nic_we, nic_addr, nic_di, busy, done, timeout, cfg_err);
    end
    n_checks++;
    if ({tx_count, rx_count, err_count, last_rx} !== '0) begin
      n_fail++; $display("FAIL reset_counts: got tx=%0d rx=%0d err=%0d last=%h required 0", tx_count, rx_count, err_count, last_rx);
    end
  endtask

  task automatic test_packet_build();
    int tbl_x[4] = '{3, 0, 4, 4};
    int tbl_y[4] = '{2, 0, 1, 2};
    logic [15:0] tbl_s[4] = '{16'hABCD, 16'h1234, 16'hFFFF, 16'h0001};
    logic [63:0] tbl_e[4] = '{64'h6011_0104_ABCD_0000, 64'h40F1_0104_1234_0000,
                              64'h0000_0104_FFFF_0000, 64'h2001_0104_0001_0000};
    int c;
    for (int i = 0; i < 4; i++) begin
      clear_stub();
      do_start(tbl_x[i], tbl_y[i], 1, 0, 16'h0, tbl_s[i]);
      wait_done(200, c);
      n_checks++;
      if (done !== 1'b1 || tx_count !== 8'd1) begin
        n_fail++; $display("FAIL single_write_done[%0d]: got done=%b tx_count=%0d required done=1 tx_count=1", i, done, tx_count);
      end
      n_checks++;
      if (tx_log.size() != 1 || tx_log[0] !== tbl_e[i]) begin
        n_fail++; $display("FAIL single_write_pkt[%0d]: got %0d writes first=%h required one write %h",
          i, tx_log.size(), (tx_log.size() != 0) ? tx_log[0] : 64'h0, tbl_e[i]);
      end
    end
  endtask

  task automatic test_cfg_err();
    int en0, c;
    int bx[2] = '{5, 1};
    int by[2] = '{0, 7};
    for (int i = 0; i < 2; i++) begin
      clear_stub();
      en0 = en_cycles;
      do_start(bx[i], by[i], 3, 3, 16'h0, 16'h0);
      repeat (3) @(negedge clk);
      n_checks++;
      if (cfg_err !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL cfg_err[%0d]: got cfg_err=%b done=%b busy=%b required 1 1 0", i, cfg_err, done, busy);
      end
      n_checks++;
      if (en_cycles != en0) begin
        n_fail++; $display("FAIL cfg_no_access[%0d]: got %0d NIC accesses required 0", i, en_cycles - en0);
      end
    end
    // A valid empty run clears cfg_err and completes within two cycles.
    do_start(2, 1, 0, 0, 16'h0, 16'h0);
    wait_done(10, c);
    n_checks++;
    if (done !== 1'b1 || c > 2 || cfg_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_run: got done=%b after %0d cycles cfg_err=%b busy=%b required done within 2, cfg_err=0 busy=0",
        done, c, cfg_err, busy);
    end
  endtask

  task automatic test_loopback(input logic [15:0] es, input int n, input int exp_err);
    int c;
    clear_stub();
    loopback = 1;
    do_start(0, 0, n, n, es, 16'h0010);
    wait_done(1000, c);
    n_checks++;
    if (done !== 1'b1 || timeout !== 1'b0 || tx_count !== CW'(n) || rx_count !== CW'(n)) begin
      n_fail++; $display("FAIL loop_counts(es=%h): got done=%b to=%b tx=%0d rx=%0d required 1 0 %0d %0d",
        es, done, timeout, tx_count, rx_count, n, n);
    end
    n_checks++;
    if (err_count !== CW'(exp_err)) begin
      n_fail++; $display("FAIL loop_err(es=%h): got %0d required %0d", es, err_count, exp_err);
    end
    n_checks++;
    if (last_rx !== model_pkt(0, 0, 16'h0010 + 16'(n - 1))) begin
      n_fail++; $display("FAIL loop_last_rx: got %h required %h", last_rx, model_pkt(0, 0, 16'h0010 + 16'(n - 1)));
    end
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (i >= rx_seen.size() || rx_seen[i][31:16] !== 16'h0010 + 16'(i)) begin
        n_fail++; $display("FAIL loop_rx_data[%0d]: got %h required %h", i,
          (i < rx_seen.size()) ? rx_seen[i][31:16] : 16'hxxxx, 16'h0010 + 16'(i));
      end
    end
  endtask

  task automatic test_random();
    int tx, ty, txn, rxn, c, e_err;
    logic [15:0] sd, es;
    logic [63:0] p, e_last;
    for (int r = 0; r < 8; r++) begin
      clear_stub();
      rand_full = 1;
      tx = $urandom_range(0, MX - 1); ty = $urandom_range(0, MY - 1);
      txn = $urandom_range(0, 6); rxn = $urandom_range(0, 6);
      sd = (r == 0) ? 16'hFFFE : 16'($urandom); es = 16'($urandom);
      e_err = 0; e_last = '0;
      for (int i = 0; i < rxn; i++) begin
        p = {$urandom, $urandom};
        p[47:32] = es; p[31:16] = sd + 16'(i);
        case ($urandom_range(0, 3))
          0: p[47:32] = es ^ 16'(1 << $urandom_range(0, 15));
          1: p[31:16] = p[31:16] + 16'($urandom_range(1, 9));
          default: ;
        endcase
        if (p[47:32] != es || p[31:16] != sd + 16'(i)) e_err++;
        rx_q.push_back(p);
        e_last = p;
      end
      for (int i = 0; i < txn; i++) exp_q.push_back(model_pkt(tx, ty, sd + 16'(i)));
      do_start(tx, ty, txn, rxn, es, sd);
      wait_done(2000, c);
      n_checks++;
      if (done !== 1'b1 || timeout !== 1'b0 || busy !== 1'b0 || cfg_err !== 1'b0) begin
        n_fail++; $display("FAIL rand_status[%0d]: got done=%b to=%b busy=%b cfg=%b required 1 0 0 0", r, done, timeout, busy, cfg_err);
      end
      n_checks++;
      if (tx_count !== CW'(txn) || rx_count !== CW'(rxn) || err_count !== CW'(e_err)) begin
        n_fail++; $display("FAIL rand_counts[%0d]: got tx=%0d rx=%0d err=%0d required %0d %0d %0d",
          r, tx_count, rx_count, err_count, txn, rxn, e_err);
      end
      n_checks++;
      if (last_rx !== e_last) begin
        n_fail++; $display("FAIL rand_last_rx[%0d]: got %h required %h", r, last_rx, e_last);
      end
      n_checks++;
      if (tx_log.size() != exp_q.size() || rx_q.size() != 0) begin
        n_fail++; $display("FAIL rand_traffic[%0d]: got %0d writes, %0d unread required %0d writes, 0 unread",
          r, tx_log.size(), rx_q.size(), exp_q.size());
      end
      while (exp_q.size() != 0 && tx_log.size() != 0) begin
        n_checks++;
        if (tx_log[0] !== exp_q[0]) begin
          n_fail++; $display("FAIL rand_pkt[%0d]: got %h required %h", r, tx_log[0], exp_q[0]);
        end
        void'(tx_log.pop_front());
        void'(exp_q.pop_front());
      end
      n_checks++;
      if (proto_err != 0) begin
        n_fail++; $display("FAIL rand_nic_idle_zero[%0d]: got %0d bad cycles required 0", r, proto_err);
      end
    end
  endtask

  task automatic test_backpressure();
    int c, release_cyc;
    logic [63:0] p;
    clear_stub();
    for (int i = 0; i < 3; i++) begin
      p = '0; p[47:32] = 16'h5555; p[31:16] = 16'h0100 + 16'(i);
      rx_q.push_back(p);
    end
    out_full_stall = 1;
    do_start(3, 1, 1, 3, 16'h5555, 16'h0100);
    repeat (10) @(posedge clk);
    do_start(0, 0, 0, 0, 16'h0, 16'h0);
    repeat (18) @(posedge clk);
    @(negedge clk);
    out_full_stall = 0;
    release_cyc = cyc;
    wait_done(500, c);
    n_checks++;
    if (done !== 1'b1 || timeout !== 1'b0 || rx_count !== 8'd3 || err_count !== 8'd0 || tx_count !== 8'd1) begin
      n_fail++; $display("FAIL bp_status: got done=%b to=%b rx=%0d err=%0d tx=%0d required 1 0 3 0 1",
        done, timeout, rx_count, err_count, tx_count);
    end
    n_checks++;
    if (read_cyc_q.size() != 3 || read_cyc_q[2] >= release_cyc) begin
      n_fail++; $display("FAIL bp_reads_during_stall: got %0d reads, last at %0d required 3 reads before %0d",
        read_cyc_q.size(), (read_cyc_q.size() != 0) ? read_cyc_q[$] : -1, release_cyc);
    end
    n_checks++;
    if (tx_log.size() != 1 || write_cyc <= release_cyc || tx_log[0] !== model_pkt(3, 1, 16'h0100)) begin
      n_fail++; $display("FAIL bp_write_after_release: got %0d writes at %0d (release %0d) first=%h required one write %h",
        tx_log.size(), write_cyc, release_cyc, (tx_log.size() != 0) ? tx_log[0] : 64'h0, model_pkt(3, 1, 16'h0100));
    end
  endtask

  task automatic test_watchdog();
    int c;
    clear_stub();
    do_start(1, 1, 0, 1, 16'h0, 16'h0);
    wait_done(200, c);
    n_checks++;
    if (done !== 1'b1 || timeout !== 1'b1 || busy !== 1'b0 || rx_count !== 8'd0) begin
      n_fail++; $display("FAIL wd_status: got done=%b to=%b busy=%b rx=%0d required 1 1 0 0", done, timeout, busy, rx_count);
    end
    n_checks++;
    if (c < PT + 1 || c > PT + 2) begin
      n_fail++; $display("FAIL wd_latency: got done %0d cycles after start required %0d..%0d", c - 1, PT, PT + 1);
    end
  endtask

  task automatic test_reset_mid_write();
    int nwe = 0, guard = 0, c;
    clear_stub();
    loopback = 1;
    do_start(2, 0, 3, 3, OWN_ID, 16'h7000);
    while (nwe < 2 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (nic_we === 1'b1) nwe++;
    end
    n_checks++;
    if (nwe != 2) begin
      n_fail++; $display("FAIL rst_reach_write: got %0d writes required 2", nwe);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({nic_en, nic_we, nic_addr, nic_di} !== '0) begin
      n_fail++; $display("FAIL rst_async_nic: got en=%b we=%b addr=%b di=%h required 0", nic_en, nic_we, nic_addr, nic_di);
    end
    n_checks++;
    if ({busy, done, timeout, cfg_err, tx_count, rx_count, err_count, last_rx} !== '0) begin
      n_fail++; $display("FAIL rst_async_state: got busy=%b done=%b tx=%0d rx=%0d last=%h required 0",
        busy, done, tx_count, rx_count, last_rx);
    end
    @(posedge clk); #1 reset = 1'b1;
    clear_stub();
    do_start(2, 2, 2, 0, 16'h0, 16'h0042);
    wait_done(500, c);
    n_checks++;
    if (done !== 1'b1 || tx_count !== 8'd2 || tx_log.size() != 2 || tx_log[1] !== model_pkt(2, 2, 16'h0043)) begin
      n_fail++; $display("FAIL rst_clean_rerun: got done=%b tx=%0d writes=%0d required done=1 tx=2 second=%h",
        done, tx_count, tx_log.size(), model_pkt(2, 2, 16'h0043));
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; dst_x = '0; dst_y = '0; tx_num = '0; rx_num = '0;
    exp_src = '0; seed = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    @(posedge clk); #1 reset = 1'b1;
    test_packet_build();
    test_cfg_err();
    test_loopback(OWN_ID, 4, 0);
    test_loopback(16'h0101, 2, 2);
    test_random();
    test_backpressure();
    test_watchdog();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
